// File: rtl/calc_pkg.sv
// Shared status codes, command codes and sequencer state type for the calculator
// command path.
package calc_pkg;

    localparam logic [1:0] ST_ERROR = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam logic [3:0] CMD_ADD  = 4'hA;
    localparam logic [3:0] CMD_SUB  = 4'hB;
    localparam logic [3:0] CMD_MUL  = 4'hC;
    localparam logic [3:0] CMD_EQ   = 4'hE;
    localparam logic [3:0] CMD_BKSP = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_READY,
        FAULT
    } seq_state_t;

endpackage

// File: rtl/calc_key_fifo.sv
// DEPTH x 4 synchronous key FIFO with occupancy count and a synchronous flush.
// The head entry is presented combinationally on rdata.
module calc_key_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [3:0]                   wdata,
    output logic [3:0]                   rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Queues keypad codes and issues them one at a time to the calculator core,
// handshaking each against the core status with a bounded acknowledge wait.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [3:0]  IDLE_CMD = 4'hD
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    output logic                         key_ready,
    input  logic [1:0]                   calc_status,
    output logic [3:0]                   cmd,
    output logic                         cmd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         timeout,
    output logic                         fault,
    output logic [7:0]                   issued_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    seq_state_t    state;
    logic [TW-1:0] timer;
    logic          fifo_full;
    logic          fifo_empty;
    logic [3:0]    head;
    logic          push;
    logic          pop;
    logic          st_busy;

    // Encoding 11 is not defined by the core and is handled as busy.
    assign st_busy   = (calc_status == ST_BUSY) || (calc_status == 2'b11);
    assign key_ready = ~fifo_full & ~fault;
    assign push      = key_valid & key_ready;
    assign pop       = (state == IDLE) & ~fifo_empty & (calc_status == ST_READY);

    calc_key_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (state == FAULT),
        .push  (push),
        .pop   (pop),
        .wdata (key_code),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cmd        <= IDLE_CMD;
            cmd_valid  <= 1'b0;
            timeout    <= 1'b0;
            fault      <= 1'b0;
            issued_cnt <= 8'd0;
            timer      <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        cmd       <= head;
                        cmd_valid <= 1'b1;
                        timer     <= '0;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (calc_status == ST_ERROR) begin
                        cmd_valid <= 1'b0;
                        cmd       <= IDLE_CMD;
                        fault     <= 1'b1;
                        state     <= FAULT;
                    end else if (st_busy) begin
                        cmd_valid  <= 1'b0;
                        cmd        <= IDLE_CMD;
                        issued_cnt <= issued_cnt + 8'd1;
                        state      <= WAIT_READY;
                    end else if (timer == TIMER_MAX) begin
                        cmd_valid <= 1'b0;
                        cmd       <= IDLE_CMD;
                        timeout   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_READY: begin
                    if (calc_status == ST_ERROR) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else if (calc_status == ST_READY) begin
                        state <= IDLE;
                    end
                end
                FAULT: begin
                    fault     <= 1'b1;
                    cmd_valid <= 1'b0;
                    cmd       <= IDLE_CMD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer: a vector table for FIFO fill behaviour plus
// hand sequences for ordering, timeout, fault, reset and simultaneous push/pop.
module tb_calc_cmd_sequencer;
    import calc_pkg::*;

    logic       clock;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [1:0] calc_status;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [3:0] fifo_count;
    logic       timeout;
    logic       fault;
    logic [7:0] issued_cnt;

    int total;
    int bad;

    calc_cmd_sequencer #(
        .DEPTH    (8),
        .TIMEOUT  (64),
        .IDLE_CMD (4'hD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .calc_status (calc_status),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .fifo_count  (fifo_count),
        .timeout     (timeout),
        .fault       (fault),
        .issued_cnt  (issued_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic [1:0] st;
        logic       exp_ready;
        int         exp_count;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] st);
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        calc_status = st;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push_key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
    endtask

    logic [3:0] got [4];
    logic [3:0] exp_seq [4];
    int n, busy_left, vcyc, pulses, saw7, vcount;

    initial begin
        total = 0;
        bad   = 0;

        // Test 2 table: core held busy, nine back-to-back pushes.
        vecs[0] = '{1'b1, 4'h0, ST_BUSY, 1'b1, 1, 1'b0};
        vecs[1] = '{1'b1, 4'h1, ST_BUSY, 1'b1, 2, 1'b0};
        vecs[2] = '{1'b1, 4'h2, ST_BUSY, 1'b1, 3, 1'b0};
        vecs[3] = '{1'b1, 4'h3, ST_BUSY, 1'b1, 4, 1'b0};
        vecs[4] = '{1'b1, 4'h4, ST_BUSY, 1'b1, 5, 1'b0};
        vecs[5] = '{1'b1, 4'h5, ST_BUSY, 1'b1, 6, 1'b0};
        vecs[6] = '{1'b1, 4'h6, ST_BUSY, 1'b1, 7, 1'b0};
        vecs[7] = '{1'b1, 4'h7, ST_BUSY, 1'b0, 8, 1'b0};
        vecs[8] = '{1'b1, 4'h8, ST_BUSY, 1'b0, 8, 1'b0};
        vecs[9] = '{1'b0, 4'h0, 2'b11,   1'b0, 8, 1'b0};

        exp_seq[0] = 4'h1;
        exp_seq[1] = CMD_ADD;
        exp_seq[2] = 4'h2;
        exp_seq[3] = CMD_EQ;

        // Reset values
        do_reset(ST_BUSY);
        chk("rst_cmd", int'(cmd), 13);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_key_ready", int'(key_ready), 1);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_issued_cnt", int'(issued_cnt), 0);

        // Test 2: fill, overflow ignored
        for (int i = 0; i < 10; i++) begin
            key_valid   = vecs[i].kv;
            key_code    = vecs[i].kc;
            calc_status = vecs[i].st;
            step();
            chk($sformatf("fill%0d_count", i), int'(fifo_count), vecs[i].exp_count);
            chk($sformatf("fill%0d_ready", i), int'(key_ready), int'(vecs[i].exp_ready));
            chk($sformatf("fill%0d_valid", i), int'(cmd_valid), int'(vecs[i].exp_valid));
        end
        key_valid = 1'b0;

        // Test 1: ordered issue with a responsive core model
        do_reset(ST_BUSY);
        push_key(4'h1);
        push_key(CMD_ADD);
        push_key(4'h2);
        push_key(CMD_EQ);
        chk("t1_queued", int'(fifo_count), 4);
        calc_status = ST_READY;
        n = 0;
        busy_left = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (calc_status == ST_READY && cmd_valid) begin
                if (n < 4) got[n] = cmd;
                n++;
                calc_status = ST_BUSY;
                busy_left = 2;
            end else if (calc_status == ST_BUSY) begin
                busy_left--;
                if (busy_left == 0) calc_status = ST_READY;
            end else if (!cmd_valid) begin
                chk("t1_idle_cmd", int'(cmd), 13);
            end
        end
        chk("t1_num_cmds", n, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_cmd%0d", i), int'(got[i]), int'(exp_seq[i]));
        chk("t1_issued_cnt", int'(issued_cnt), 4);
        chk("t1_fifo_count", int'(fifo_count), 0);

        // Test 3: core stuck READY -> timeout, then next key issued
        do_reset(ST_READY);
        key_valid = 1'b1;
        key_code  = 4'h5;
        step();
        key_code  = 4'h7;
        step();
        key_valid = 1'b0;
        vcyc = 0;
        pulses = 0;
        saw7 = 0;
        for (int c = 0; c < 100; c++) begin
            if (cmd_valid && cmd == 4'h5) vcyc++;
            if (timeout) pulses++;
            if (cmd_valid && cmd == 4'h7) begin
                saw7 = 1;
                break;
            end
            step();
        end
        chk("t3_valid_cycles", vcyc, 64);
        chk("t3_timeout_pulses", pulses, 1);
        chk("t3_next_issued", saw7, 1);
        chk("t3_issued_cnt", int'(issued_cnt), 0);

        // Test 4: ERROR in WAIT_READY with 3 keys queued
        do_reset(ST_BUSY);
        push_key(4'h1);
        push_key(4'h2);
        push_key(4'h3);
        push_key(4'h4);
        calc_status = ST_READY;
        step();
        chk("t4_issue", int'(cmd_valid), 1);
        calc_status = ST_BUSY;
        step();
        chk("t4_wait_ready_count", int'(fifo_count), 3);
        calc_status = ST_ERROR;
        step();
        chk("t4_fault", int'(fault), 1);
        chk("t4_key_ready", int'(key_ready), 0);
        calc_status = ST_READY;
        key_valid = 1'b1;
        key_code = 4'h9;
        step();
        chk("t4_flushed", int'(fifo_count), 0);
        for (int c = 0; c < 5; c++) step();
        key_valid = 1'b0;
        chk("t4_fault_held", int'(fault), 1);
        chk("t4_count_held", int'(fifo_count), 0);
        chk("t4_no_cmd", int'(cmd_valid), 0);

        // Test 5: reset while in WAIT_ACK with 3 queued
        do_reset(ST_BUSY);
        push_key(4'h1);
        push_key(4'h2);
        push_key(4'h3);
        push_key(4'h4);
        calc_status = ST_READY;
        step();
        chk("t5_in_wait_ack", int'(cmd_valid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_cmd", int'(cmd), 13);
        chk("t5_cmd_valid", int'(cmd_valid), 0);
        chk("t5_fifo_count", int'(fifo_count), 0);
        chk("t5_key_ready", int'(key_ready), 1);
        chk("t5_issued", int'(issued_cnt), 0);
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (cmd_valid) vcount++;
        end
        chk("t5_no_issue", vcount, 0);

        // Test 6: simultaneous pop and push keeps count
        do_reset(ST_BUSY);
        push_key(4'h3);
        chk("t6_pre_count", int'(fifo_count), 1);
        calc_status = ST_READY;
        key_valid = 1'b1;
        key_code = 4'h8;
        step();
        key_valid = 1'b0;
        chk("t6_count", int'(fifo_count), 1);
        chk("t6_valid", int'(cmd_valid), 1);
        chk("t6_cmd", int'(cmd), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
